multicycle_slice_adder: RTL

Parametrised sequential adder. It adds two WIDTH-bit operands over several cycles, SLICE bits per cycle, starting at the LSB slice. The carry is registered between slices, so the critical path is one SLICE-bit ripple chain regardless of WIDTH. It sits beside the 74181 ALU datapath components as the wide-operand arithmetic unit, with a valid/ready handshake on both sides.

---
 rtl/multicycle_slice_adder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multicycle_slice_adder.sv
// multicycle_slice_adder: adds two WIDTH-bit operands SLICE bits per cycle,
// LSB slice first, with the carry registered between slices so the critical
// path is one SLICE-bit ripple regardless of WIDTH. Valid/ready on both sides.
//
// Optional: define MULTICYCLE_SLICE_ADDER_OVF_EN to build the signed-overflow
// flag; otherwise ovf is tied low and no overflow logic exists.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one slice added per edge, idx_q selects the slice
// DONE  | result held with out_valid high until out_ready

module multicycle_slice_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    // Reject geometries where the slices do not tile the operand exactly.
    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
            $error("multicycle_slice_adder: WIDTH must be >= 1 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [WIDTH-1:0] f_q;
    logic             c_out_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [31:0]      base_d;
    logic [SLICE-1:0] slice_a_d;
    logic [SLICE-1:0] slice_b_d;
    logic [SLICE:0]   sum_d;

    // Current slice of the latched operands plus the registered carry.
    always_comb begin
        base_d    = 32'(idx_q) * SLICE;
        slice_a_d = a_q[base_d +: SLICE];
        slice_b_d = b_q[base_d +: SLICE];
        sum_d     = {1'b0, slice_a_d} + {1'b0, slice_b_d} + {{SLICE{1'b0}}, carry_q};
    end

`ifdef MULTICYCLE_SLICE_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // On the last slice sum_d[SLICE-1] is the final sum MSB.
    always_comb begin
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[SLICE-1] != a_q[WIDTH-1]);
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            f_q         <= '0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MULTICYCLE_SLICE_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= c_in;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    f_q[base_d +: SLICE] <= sum_d[SLICE-1:0];
                    carry_q              <= sum_d[SLICE];
                    if (idx_q == LAST_IDX) begin
                        c_out_q     <= sum_d[SLICE];
`ifdef MULTICYCLE_SLICE_ADDER_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign c_out     = c_out_q;

endmodule
